// File: rtl/uart_rx_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_controller: 16x-oversampled UART receiver, single-entry output   |
// | Optional parity stage: define UART_RX_PARITY_EN.         Revision: 1.0   |
// +--------------------------------------------------------------------------+
module uart_rx_controller #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 baud_clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy,
  output logic [2:0]           current_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [2:0] c_LAST_BIT = 3'(DATA_BITS - 1);

  state_t               r_state, w_next;
  logic                 r_sync1, r_rx_s;
  logic [3:0]           r_sample_cnt;
  logic [2:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_valid, r_frame_err, r_parity_err, r_overrun_err;
  logic                 w_cnt_clr, w_bit_clr, w_bit_inc, w_shift;
  logic                 w_par_chk, w_stop_eval, w_tick, w_par_bad, w_deliver;

  assign w_tick = (r_sample_cnt == 4'd15);

  always_comb begin
    w_next      = r_state;
    w_cnt_clr   = 1'b0;
    w_bit_clr   = 1'b0;
    w_bit_inc   = 1'b0;
    w_shift     = 1'b0;
    w_par_chk   = 1'b0;
    w_stop_eval = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_next    = S_START;
          w_cnt_clr = 1'b1;
        end
      end
      S_START: begin
        // Mid-start re-check rejects glitches shorter than half a bit.
        if (r_sample_cnt == 4'd7) begin
          if (!r_rx_s) begin
            w_next    = S_DATA;
            w_cnt_clr = 1'b1;
            w_bit_clr = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift = 1'b1;
          if (r_bit_cnt == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            w_next = S_PARITY;
`else
            w_next = S_STOP;
`endif
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_par_chk = 1'b1;
          w_next    = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_stop_eval = 1'b1;
          w_next      = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic w_par_exp;
  assign w_par_exp = (^r_shift) ^ (PARITY_ODD != 0);

  always_ff @(posedge baud_clk) begin
    if (rst)            r_par_bad <= 1'b0;
    else if (w_bit_clr) r_par_bad <= 1'b0;
    else if (w_par_chk) r_par_bad <= (r_rx_s != w_par_exp);
  end
  assign w_par_bad = r_par_bad;
`else
  logic w_unused_par;
  assign w_unused_par = (PARITY_ODD != 0) ^ w_par_chk;
  assign w_par_bad    = 1'b0;
`endif

  assign w_deliver = w_stop_eval & r_rx_s & ~w_par_bad;

  always_ff @(posedge baud_clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      r_sync1       <= 1'b1;
      r_rx_s        <= 1'b1;
      r_sample_cnt  <= 4'd0;
      r_bit_cnt     <= 3'd0;
      r_shift       <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_frame_err   <= 1'b0;
      r_parity_err  <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_sync1 <= rx_in;
      r_rx_s  <= r_sync1;
      if (w_cnt_clr)              r_sample_cnt <= 4'd0;
      else if (r_state != S_IDLE) r_sample_cnt <= r_sample_cnt + 4'd1;
      if (w_bit_clr)      r_bit_cnt <= 3'd0;
      else if (w_bit_inc) r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_shift) r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
      r_frame_err   <= w_stop_eval & ~r_rx_s;
      r_parity_err  <= w_stop_eval & w_par_bad;
      r_overrun_err <= w_deliver & r_valid & ~rx_ready;
      // A consumer pop in the delivery cycle frees the slot for the new word.
      if (w_deliver && (!r_valid || rx_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign frame_err     = r_frame_err;
  assign parity_err    = r_parity_err;
  assign overrun_err   = r_overrun_err;
  assign busy          = (r_state != S_IDLE);
  assign current_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx_controller: directed and randomized bench for the UART rx     |
// | Honours UART_RX_PARITY_EN when defined.                  Revision: 1.0   |
// +--------------------------------------------------------------------------+
module tb_uart_rx_controller;
  localparam int DATA_BITS  = 8;
  localparam int PARITY_ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int c_PB = 1;
  localparam int c_FIRST_STOP_EDGE = 170;
`else
  localparam int c_PB = 0;
  localparam int c_FIRST_STOP_EDGE = 154;
`endif
  localparam int c_NB    = DATA_BITS + 2 + c_PB;
  localparam int c_FRAME = 16 * c_NB;
  localparam int c_STOP  = 10 + 16 * (c_NB - 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun_err, busy;
  logic [2:0] current_state;

  always #5 clk = ~clk;

  uart_rx_controller #(.DATA_BITS(DATA_BITS), .PARITY_ODD(PARITY_ODD)) dut (
    .baud_clk(clk), .rst(rst), .rx_in(rx_in), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .overrun_err(overrun_err), .busy(busy),
    .current_state(current_state)
  );

  int vectors = 0;
  int miscompares = 0;
  bit wave[$];
  int o_fe_n, o_fe_at, o_pe_n, o_pe_at, o_ov_n, o_ov_at;
  int o_vrise, o_vfall, o_bhi, o_blo;
  logic [15:0] o_snap;

  function automatic bit par_bit(input logic [7:0] d);
    return bit'(($countones(d) + PARITY_ODD) % 2);
  endfunction

  task automatic push_idle(input int n);
    repeat (n) wave.push_back(1'b1);
  endtask

  task automatic push_frame(input logic [7:0] d, input bit p, input bit stop);
    repeat (16) wave.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) repeat (16) wave.push_back(d[i]);
    if (c_PB == 1) repeat (16) wave.push_back(p);
    repeat (16) wave.push_back(stop);
  endtask

  // Plays the queued line waveform (edge 0 = first sample) and records event edges.
  task automatic play(input int n, input int ready_at, input bit ready_dflt, input int rst_at);
    logic prev_v;
    int   n_eff;
    n_eff = (n < 0) ? wave.size() : n;
    o_fe_n = 0; o_pe_n = 0; o_ov_n = 0;
    o_fe_at = -1; o_pe_at = -1; o_ov_at = -1;
    o_vrise = -1; o_vfall = -1; o_bhi = -1; o_blo = -1;
    o_snap = '1;
    prev_v = rx_valid;
    for (int e = 0; e < n_eff; e++) begin
      rx_in    = wave[e];
      rx_ready = (e == ready_at) ? 1'b1 : ready_dflt;
      rst      = (e == rst_at);
      @(posedge clk); #1;
      if (frame_err)   begin o_fe_n++; if (o_fe_at < 0) o_fe_at = e; end
      if (parity_err)  begin o_pe_n++; if (o_pe_at < 0) o_pe_at = e; end
      if (overrun_err) begin o_ov_n++; if (o_ov_at < 0) o_ov_at = e; end
      if (rx_valid && !prev_v && o_vrise < 0) o_vrise = e;
      if (!rx_valid && prev_v && o_vfall < 0) o_vfall = e;
      if (busy && o_bhi < 0) o_bhi = e;
      else if (!busy && o_bhi >= 0 && o_blo < 0) o_blo = e;
      if (e == rst_at)
        o_snap = {rx_valid, busy, frame_err, parity_err, overrun_err, current_state, rx_data};
      prev_v = rx_valid;
    end
    rst = 1'b0; rx_ready = 1'b0; rx_in = 1'b1;
    wave.delete();
  endtask

  task automatic drain;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_in = 1'b1; rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    vectors++; if ({frame_err, parity_err, overrun_err} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b expected 000", {frame_err, parity_err, overrun_err}); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (current_state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", current_state); end
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic test_8n1;
    push_frame(8'hA5, par_bit(8'hA5), 1'b1);
    push_idle(8);
    play(-1, -1, 1'b0, -1);
    vectors++; if (o_vrise !== c_FIRST_STOP_EDGE) begin miscompares++; $display("FAIL 8n1_valid_edge: got %0d expected %0d", o_vrise, c_FIRST_STOP_EDGE); end
    vectors++; if (rx_data !== 8'hA5) begin miscompares++; $display("FAIL 8n1_data: got %h expected a5", rx_data); end
    vectors++; if (o_fe_n + o_pe_n + o_ov_n !== 0) begin miscompares++; $display("FAIL 8n1_errs: got %0d pulses expected 0", o_fe_n + o_pe_n + o_ov_n); end
    vectors++; if (o_bhi !== 2) begin miscompares++; $display("FAIL 8n1_busy_rise: got %0d expected 2", o_bhi); end
    vectors++; if (o_blo !== c_STOP) begin miscompares++; $display("FAIL 8n1_busy_fall: got %0d expected %0d", o_blo, c_STOP); end
    drain();
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL 8n1_pop: got %b expected 0", rx_valid); end
  endtask

  task automatic test_false_start;
    repeat (5) wave.push_back(1'b0);
    push_idle(40);
    play(-1, -1, 1'b0, -1);
    vectors++; if (o_bhi !== 2 || o_blo !== 10) begin miscompares++; $display("FAIL glitch_busy: got %0d..%0d expected 2..10", o_bhi, o_blo); end
    vectors++; if (o_vrise !== -1) begin miscompares++; $display("FAIL glitch_valid: got rise at %0d expected none", o_vrise); end
    vectors++; if (o_fe_n + o_ov_n !== 0) begin miscompares++; $display("FAIL glitch_errs: got %0d pulses expected 0", o_fe_n + o_ov_n); end
    vectors++; if (current_state !== 3'd0) begin miscompares++; $display("FAIL glitch_state: got %0d expected 0", current_state); end
  endtask

  task automatic test_frame_err;
    push_frame(8'h3C, par_bit(8'h3C), 1'b0);
    push_idle(32);
    play(-1, -1, 1'b0, -1);
    vectors++; if (o_fe_n !== 1 || o_fe_at !== c_STOP) begin miscompares++; $display("FAIL ferr_pulse: got %0d at %0d expected 1 at %0d", o_fe_n, o_fe_at, c_STOP); end
    vectors++; if (o_vrise !== -1) begin miscompares++; $display("FAIL ferr_valid: got rise at %0d expected none", o_vrise); end
    vectors++; if (o_pe_n + o_ov_n !== 0) begin miscompares++; $display("FAIL ferr_other: got %0d pulses expected 0", o_pe_n + o_ov_n); end
  endtask

  task automatic test_overrun;
    push_frame(8'h11, par_bit(8'h11), 1'b1);
    push_frame(8'h22, par_bit(8'h22), 1'b1);
    push_idle(8);
    play(-1, -1, 1'b0, -1);
    vectors++; if (o_ov_n !== 1 || o_ov_at !== c_FRAME + c_STOP) begin miscompares++; $display("FAIL ovr_pulse: got %0d at %0d expected 1 at %0d", o_ov_n, o_ov_at, c_FRAME + c_STOP); end
    vectors++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_keep: got %h/%b expected 11/1", rx_data, rx_valid); end
    vectors++; if (o_vrise !== c_STOP) begin miscompares++; $display("FAIL ovr_first: got %0d expected %0d", o_vrise, c_STOP); end
    drain();
  endtask

  task automatic test_refill;
    push_frame(8'h11, par_bit(8'h11), 1'b1);
    push_frame(8'h22, par_bit(8'h22), 1'b1);
    push_idle(8);
    play(-1, c_FRAME + c_STOP, 1'b0, -1);
    vectors++; if (o_ov_n !== 0) begin miscompares++; $display("FAIL refill_ovr: got %0d expected 0", o_ov_n); end
    vectors++; if (rx_data !== 8'h22 || rx_valid !== 1'b1) begin miscompares++; $display("FAIL refill_data: got %h/%b expected 22/1", rx_data, rx_valid); end
    vectors++; if (o_vfall !== -1) begin miscompares++; $display("FAIL refill_gap: got valid fall at %0d expected none", o_vfall); end
    drain();
  endtask

  task automatic test_reset_mid;
    push_frame(8'h99, par_bit(8'h99), 1'b1);
    push_frame(8'h5A, par_bit(8'h5A), 1'b1);
    play(c_FRAME + 69, -1, 1'b0, c_FRAME + 68);
    vectors++; if (o_vrise !== c_STOP) begin miscompares++; $display("FAIL rstmid_held: got %0d expected %0d", o_vrise, c_STOP); end
    vectors++; if (o_snap !== 16'h0000) begin miscompares++; $display("FAIL rstmid_outputs: got %h expected 0000", o_snap); end
    push_idle(4);
    push_frame(8'h5A, par_bit(8'h5A), 1'b1);
    push_idle(8);
    play(-1, -1, 1'b0, -1);
    vectors++; if (o_vrise !== 4 + c_STOP || rx_data !== 8'h5A) begin miscompares++; $display("FAIL rstmid_next: got %h at %0d expected 5a at %0d", rx_data, o_vrise, 4 + c_STOP); end
    vectors++; if (o_fe_n + o_pe_n + o_ov_n !== 0) begin miscompares++; $display("FAIL rstmid_errs: got %0d pulses expected 0", o_fe_n + o_pe_n + o_ov_n); end
    drain();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    push_frame(8'h07, 1'b0, 1'b1);
    push_idle(8);
    play(-1, -1, 1'b0, -1);
    vectors++; if (o_pe_n !== 1 || o_pe_at !== 170) begin miscompares++; $display("FAIL par_bad: got %0d at %0d expected 1 at 170", o_pe_n, o_pe_at); end
    vectors++; if (o_vrise !== -1 || o_fe_n !== 0) begin miscompares++; $display("FAIL par_bad_side: got rise %0d fe %0d expected none", o_vrise, o_fe_n); end
    push_frame(8'h07, 1'b1, 1'b1);
    push_idle(8);
    play(-1, -1, 1'b0, -1);
    vectors++; if (o_vrise !== 170 || rx_data !== 8'h07 || o_pe_n !== 0) begin miscompares++; $display("FAIL par_good: got %h at %0d pe %0d expected 07 at 170", rx_data, o_vrise, o_pe_n); end
    drain();
    push_frame(8'h07, 1'b0, 1'b0);
    push_idle(32);
    play(-1, -1, 1'b0, -1);
    vectors++; if (o_pe_at !== 170 || o_fe_at !== 170 || o_vrise !== -1) begin miscompares++; $display("FAIL par_both: got pe %0d fe %0d rise %0d expected 170 170 none", o_pe_at, o_fe_at, o_vrise); end
  endtask
`endif

  task automatic test_random;
    logic [7:0] ev_good[int];
    bit         ev_fe[int];
    bit         ev_pe[int];
    logic [7:0] m_data;
    bit         m_valid, rdy, dlv, exp_o;
    m_valid = 1'b0; m_data = 8'h00;
    for (int f = 0; f < 12; f++) begin
      logic [7:0] d;
      bit         stop, p, pm;
      int         base;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      p    = par_bit(d);
      if (c_PB == 1 && $urandom_range(0, 3) == 0) p = ~p;
      pm   = (c_PB == 1) && (p != par_bit(d));
      base = wave.size();
      push_frame(d, p, stop);
      if (stop && !pm) ev_good[base + c_STOP] = d;
      if (!stop) ev_fe[base + c_STOP] = 1'b1;
      if (pm)    ev_pe[base + c_STOP] = 1'b1;
      // A low stop bit keeps the line low past the sample point; give it room to recover.
      if (!stop) push_idle(16 + int'($urandom_range(0, 8)));
      else if ($urandom_range(0, 2) != 0) push_idle(int'($urandom_range(1, 20)));
    end
    push_idle(8);
    for (int e = 0; e < wave.size(); e++) begin
      rx_in = wave[e];
      rdy = ($urandom_range(0, 3) == 0);
      rx_ready = rdy;
      @(posedge clk); #1;
      dlv   = ev_good.exists(e);
      exp_o = dlv && m_valid && !rdy;
      if (dlv && (!m_valid || rdy)) begin m_data = ev_good[e]; m_valid = 1'b1; end
      else if (m_valid && rdy) m_valid = 1'b0;
      vectors++; if (rx_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid@%0d: got %b expected %b", e, rx_valid, m_valid); end
      if (m_valid) begin
        vectors++; if (rx_data !== m_data) begin miscompares++; $display("FAIL rnd_data@%0d: got %h expected %h", e, rx_data, m_data); end
      end
      vectors++; if (frame_err !== ev_fe.exists(e)) begin miscompares++; $display("FAIL rnd_fe@%0d: got %b expected %b", e, frame_err, ev_fe.exists(e)); end
      vectors++; if (parity_err !== ev_pe.exists(e)) begin miscompares++; $display("FAIL rnd_pe@%0d: got %b expected %b", e, parity_err, ev_pe.exists(e)); end
      vectors++; if (overrun_err !== exp_o) begin miscompares++; $display("FAIL rnd_ovr@%0d: got %b expected %b", e, overrun_err, exp_o); end
    end
    rx_ready = 1'b0;
    wave.delete();
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_refill();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_controller.md
# uart_rx_controller

- UART receive sequencer running on the 16x oversampled `baud_clk`.
- Detects a start bit, centres sampling mid-bit with an internal oversample counter, shifts in LSB-first data and checks the stop bit.
- Presents each received word through a single-entry valid/ready holding register.
- Sits between the serial pin synchroniser and the receive FIFO/host logic.

## Interface
- `DATA_BITS`, 8, data bits per frame; legal range 5..8.
- `PARITY_ODD`, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.
- `baud_clk`  in  1  16x oversampled bit clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_in`  in  1  asynchronous serial line; idles high.
- `rx_ready`  in  1  consumer accepts `rx_data` this cycle.
- `rx_data`  out  DATA_BITS  received word; stable while `rx_valid`.
- `rx_valid`  out  1  `rx_data` holds an unconsumed word.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch; tied 0 without the macro.
- `overrun_err`  out  1  one-cycle pulse: a good word was dropped because the holding register was full.
- `busy`  out  1  state != IDLE.
- `current_state`  out  3  FSM state, for debug.

## Operation
- **Input synchroniser.** `rx_in` passes through a 2-flop synchroniser to give `rx_s`. Both flops reset to 1.
- **FSM states.** IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- **Counters.** `sample_cnt` is 4-bit and wraps 15->0. `bit_cnt` is 3-bit.
- **IDLE**
  - When `rx_s`=0: go to START and clear `sample_cnt`.
- **START**
  - Increment `sample_cnt` each cycle.
  - When `sample_cnt`==7 and `rx_s`=0: go to DATA; clear `sample_cnt` and `bit_cnt`.
  - When `sample_cnt`==7 and `rx_s`=1: false start; go to IDLE with no error flag.
- **DATA**
  - When `sample_cnt`==15: shift `rx_s` into the shift register, LSB first.
  - If `bit_cnt`==DATA_BITS-1: go to PARITY (macro defined) or STOP (macro undefined).
  - Otherwise increment `bit_cnt`.
- **PARITY**
  - When `sample_cnt`==15: compare `rx_s` with the computed parity.
  - Latch the mismatch internally, then go to STOP.
- **STOP**
  - When `sample_cnt`==15: evaluate the frame, then go to IDLE. This allows back-to-back frames with no idle gap.
  - Stop bit = 1, no parity error: deliver the word to the holding register.
  - Stop bit = 0: pulse `frame_err`; discard the word.
  - Parity mismatch: pulse `parity_err`; discard the word. If the stop bit was also 0, pulse both flags in the same cycle.
- **Holding register**
  - Delivery while `rx_valid`=0: load `rx_data` and set `rx_valid`.
  - `rx_valid` && `rx_ready`: clear `rx_valid`.
  - Delivery while `rx_valid`=1 and `rx_ready`=1 in the same cycle: load the new word; `rx_valid` stays 1; no overrun.
  - Delivery while `rx_valid`=1 and `rx_ready`=0: keep the old word and pulse `overrun_err`.
- **Arithmetic.** Parity is the XOR over DATA_BITS, inverted when `PARITY_ODD`=1.

## Timing
- **Reset values.**
  - State IDLE; `rx_data`=0; all counters 0.
  - `rx_valid`, `frame_err`, `parity_err`, `overrun_err` and `busy` all 0.
  - Synchroniser flops 1.
- **Reset mid-frame.** Asserting `rst` aborts the frame. After the next edge the block is in IDLE with all outputs at their reset values, and any held word is lost.
- **Sample points.** Relative to the `rx_in` falling edge:
  - mid-start sample: 10 edges;
  - data bit n: 10+16(n+1) edges;
  - stop bit: 10+16(DATA_BITS+1) edges, plus 16 when parity is compiled in.
- **Delivery latency.** `rx_valid` rises on the edge that samples the stop bit.
- **Error flags.** All error pulses are exactly one cycle wide, on that same edge.
- **`rx_ready` while empty.** `rx_ready` has no effect when `rx_valid`=0.
- **Glitch rejection.** A low glitch shorter than 8 `baud_clk` cycles on `rx_s` is rejected at the mid-start check.

## Configuration
- **Macro:** `UART_RX_PARITY_EN`.
- **Defined:** the PARITY state is present; the frame is start + DATA_BITS + parity + stop; `parity_err` is live.
- **Undefined:**
  - PARITY is never entered; the frame is start + DATA_BITS + stop.
  - `parity_err` is tied to 0 and `PARITY_ODD` is ignored.
  - The port list is unchanged.

## Test plan
1. **8N1 delivery.** `rx_in` low just before edge 0, then bits of 0xA5 LSB first at 16 cycles/bit, then stop=1 -> `rx_valid`=1 after edge 154, `rx_data`=0xA5, no error flags.
2. **False start.** 5-cycle low glitch on `rx_in` -> START then IDLE; `rx_valid`, `frame_err` and `overrun_err` stay 0.
3. **Framing error.** 0x3C frame with stop bit 0 -> one-cycle `frame_err` on the stop-sample edge; `rx_valid` stays 0.
4. **Overrun and same-cycle refill.**
   - Two back-to-back frames 0x11, 0x22 with `rx_ready`=0 -> `overrun_err` pulse; `rx_data` stays 0x11.
   - Repeat with `rx_ready`=1 on the second delivery edge -> `rx_data`=0x22, `rx_valid` stays 1, no overrun.
5. **Reset mid-frame.** Assert `rst` during DATA bit 3 -> IDLE, `busy`=0, all outputs 0; the next full frame 0x5A is received correctly.
6. **Parity (`UART_RX_PARITY_EN`, `PARITY_ODD`=0).** 0x07 with parity bit 0 -> `parity_err` pulse, no `rx_valid`. With parity bit 1 -> `rx_data`=0x07 after edge 170.
